// File: rtl/pipelined_ks_adder.sv
// Pipelined Kogge-Stone adder/subtractor with a valid/ready stream interface.
// One beat per cycle; every accepted beat emerges LEVELS+2 cycles after it is
// presented unless the consumer stalls.
//
// Handshake: an input beat transfers when in_valid && in_ready, an output beat
// transfers when out_valid && out_ready. The whole pipeline freezes as a unit
// whenever a result is presented but not taken (stall = out_valid && !out_ready),
// and in_ready is simply !stall, so it never looks at in_valid.
module pipelined_ks_adder #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int LEVELS = $clog2(WIDTH);
  localparam int LAT    = LEVELS + 2;

  // Prefix vectors use index 0 for the incoming carry c0 (the "bit -1"
  // generate) and index i+1 for operand bit i. Only the low WIDTH indices are
  // needed: carry into bit i is the group generate over indices [0..i]. The
  // MSB's own generate/propagate are carried separately to form cout.

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             c0;
  logic [WIDTH-1:0] g_in;
  logic [WIDTH-1:0] p_in;

  logic [LAT-2:0]   v_q;
  logic [WIDTH-1:0] g_q  [0:LEVELS];
  logic [WIDTH-1:0] p_q  [0:LEVELS-1];
  logic [WIDTH-1:0] ps_q [0:LEVELS];
  logic [LEVELS:0]  gm_q;

  logic [WIDTH-1:0] g_nx [1:LEVELS];
  logic [WIDTH-1:0] p_nx [1:LEVELS];
  logic             unused_p;

  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] sum_nx;
  logic             cout_nx;
  logic             ovf_nx;
  logic             zero_nx;

  assign advance  = !(out_valid && !out_ready);
  assign in_ready = advance;

  // The last level's group propagate is never consumed.
  assign unused_p = ^p_nx[LEVELS];

  // Operand conditioning: invert b for the subtract modes and pick c0.
  always_comb begin
    b_eff = mode[0] ? ~b : b;
    case (mode)
      2'b00:   c0 = 1'b0;
      2'b01:   c0 = 1'b1;
      default: c0 = cin;
    endcase
    g_in = {a[WIDTH-2:0] & b_eff[WIDTH-2:0], c0};
    p_in = {a[WIDTH-2:0] ^ b_eff[WIDTH-2:0], 1'b0};
  end

  // Kogge-Stone levels: level k combines each node with the one 2^(k-1) below.
  always_comb begin
    for (int k = 1; k <= LEVELS; k++) begin
      g_nx[k] = g_q[k-1];
      p_nx[k] = p_q[k-1];
      for (int i = (1 << (k - 1)); i < WIDTH; i++) begin
        g_nx[k][i] = g_q[k-1][i] | (p_q[k-1][i] & g_q[k-1][i-(1 << (k - 1))]);
        p_nx[k][i] = p_q[k-1][i] & p_q[k-1][i-(1 << (k - 1))];
      end
    end
  end

  // Final stage: sum bits, carry out of the MSB, signed overflow, zero flag.
  always_comb begin
    carry   = g_q[LEVELS];
    sum_nx  = ps_q[LEVELS] ^ carry;
    cout_nx = gm_q[LEVELS] | (ps_q[LEVELS][WIDTH-1] & carry[WIDTH-1]);
    ovf_nx  = carry[WIDTH-1] ^ cout_nx;
    zero_nx = (sum_nx == '0);
  end

  // Pipeline registers: all stages advance together or hold together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q       <= '0;
      gm_q      <= '0;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
      for (int k = 0; k <= LEVELS; k++) begin
        g_q[k]  <= '0;
        ps_q[k] <= '0;
      end
      for (int k = 0; k < LEVELS; k++) begin
        p_q[k] <= '0;
      end
    end else if (advance) begin
      v_q[0]  <= in_valid;
      g_q[0]  <= g_in;
      p_q[0]  <= p_in;
      ps_q[0] <= a ^ b_eff;
      gm_q[0] <= a[WIDTH-1] & b_eff[WIDTH-1];
      for (int k = 1; k <= LEVELS; k++) begin
        v_q[k]  <= v_q[k-1];
        g_q[k]  <= g_nx[k];
        ps_q[k] <= ps_q[k-1];
        gm_q[k] <= gm_q[k-1];
      end
      for (int k = 1; k < LEVELS; k++) begin
        p_q[k] <= p_nx[k];
      end
      out_valid <= v_q[LEVELS];
      sum       <= sum_nx;
      cout      <= cout_nx;
      ovf       <= ovf_nx;
      zero      <= zero_nx;
    end
  end

endmodule

// File: tb/tb_pipelined_ks_adder.sv
// Bench for pipelined_ks_adder: four instances (WIDTH 4, 8, 32, 64) share one
// stimulus bus; only the selected lane sees in_valid. A driver pushes expected
// results into a queue, and a monitor pops and compares at each output beat.
module tb_pipelined_ks_adder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [63:0] a;
  logic [63:0] b;
  logic        cin;
  logic [1:0]  mode;
  logic        out_ready;
  logic [1:0]  lane;

  logic [3:0]  iv_l;
  logic [3:0]  ir;
  logic [3:0]  ov;
  logic [3:0]  co;
  logic [3:0]  of;
  logic [3:0]  z;
  logic [3:0]  s4;
  logic [7:0]  s8;
  logic [31:0] s32;
  logic [63:0] s64;

  logic        ir_m;
  logic        ov_m;
  logic [63:0] sum_m;
  logic [66:0] out_m;

  logic        ready_rand;
  logic        hold_low;
  logic        lat_check;

  int          errors;
  int          checks;
  int          cyc;

  logic [66:0] exp_q[$];
  int          cyc_q[$];

  // Clock and cycle counter
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  assign iv_l = in_valid ? (4'b0001 << lane) : 4'b0000;

  pipelined_ks_adder #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_l[0]), .in_ready(ir[0]),
    .a(a[3:0]), .b(b[3:0]), .cin(cin), .mode(mode),
    .out_valid(ov[0]), .out_ready(out_ready), .sum(s4),
    .cout(co[0]), .ovf(of[0]), .zero(z[0]));

  pipelined_ks_adder #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_l[1]), .in_ready(ir[1]),
    .a(a[7:0]), .b(b[7:0]), .cin(cin), .mode(mode),
    .out_valid(ov[1]), .out_ready(out_ready), .sum(s8),
    .cout(co[1]), .ovf(of[1]), .zero(z[1]));

  pipelined_ks_adder #(.WIDTH(32)) u_w32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_l[2]), .in_ready(ir[2]),
    .a(a[31:0]), .b(b[31:0]), .cin(cin), .mode(mode),
    .out_valid(ov[2]), .out_ready(out_ready), .sum(s32),
    .cout(co[2]), .ovf(of[2]), .zero(z[2]));

  pipelined_ks_adder #(.WIDTH(64)) u_w64 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_l[3]), .in_ready(ir[3]),
    .a(a), .b(b), .cin(cin), .mode(mode),
    .out_valid(ov[3]), .out_ready(out_ready), .sum(s64),
    .cout(co[3]), .ovf(of[3]), .zero(z[3]));

  // View of the selected lane
  always_comb begin
    case (lane)
      2'd0:    sum_m = {60'b0, s4};
      2'd1:    sum_m = {56'b0, s8};
      2'd2:    sum_m = {32'b0, s32};
      default: sum_m = s64;
    endcase
    ir_m  = ir[lane];
    ov_m  = ov[lane];
    out_m = {z[lane], of[lane], co[lane], sum_m};
  end

  function automatic int width_of(input logic [1:0] l);
    case (l)
      2'd0:    return 4;
      2'd1:    return 8;
      2'd2:    return 32;
      default: return 64;
    endcase
  endfunction

  function automatic int lat_of(input logic [1:0] l);
    case (l)
      2'd0:    return 4;
      2'd1:    return 5;
      2'd2:    return 7;
      default: return 8;
    endcase
  endfunction

  function automatic logic [66:0] pk(input logic zf, input logic vf,
                                     input logic cf, input logic [63:0] s);
    return {zf, vf, cf, s};
  endfunction

  // Reference: plain unsigned and signed arithmetic on the masked operands.
  function automatic logic [66:0] ref_model(input int w, input logic [63:0] av,
                                            input logic [63:0] bv, input logic ci,
                                            input logic [1:0] md);
    logic [63:0]        mask;
    logic [63:0]        am;
    logic [63:0]        bm;
    logic [63:0]        sm;
    logic               c0;
    logic [65:0]        total;
    logic signed [66:0] sa;
    logic signed [66:0] sb;
    logic signed [66:0] ss;
    logic signed [66:0] hi;
    logic signed [66:0] lo;
    logic               cf;
    logic               vf;
    mask  = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    am    = av & mask;
    bm    = (md[0] ? ~bv : bv) & mask;
    c0    = (md == 2'b00) ? 1'b0 : ((md == 2'b01) ? 1'b1 : ci);
    total = {2'b0, am} + {2'b0, bm} + {65'b0, c0};
    sm    = total[63:0] & mask;
    cf    = total[w];
    sa    = $signed({3'b0, am});
    if (am[w-1]) sa = sa - (67'sd1 <<< w);
    sb    = $signed({3'b0, bm});
    if (bm[w-1]) sb = sb - (67'sd1 <<< w);
    ss    = sa + sb + $signed({66'b0, c0});
    hi    = (67'sd1 <<< (w - 1)) - 67'sd1;
    lo    = -(67'sd1 <<< (w - 1));
    vf    = (ss > hi) || (ss < lo);
    return {(sm == 64'd0), vf, cf, sm};
  endfunction

  task automatic check(input string name, input logic [66:0] act, input logic [66:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Consumer: out_ready is 1, random, or forced low by the main sequence.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (hold_low)        out_ready = 1'b0;
      else if (ready_rand) out_ready = ($urandom_range(0, 3) != 0);
      else                 out_ready = 1'b1;
    end
  end

  // Driver: called at posedge+1; holds the beat until it is accepted.
  task automatic send(input logic [63:0] av, input logic [63:0] bv, input logic ci,
                      input logic [1:0] md, input logic use_ref, input logic [66:0] given);
    logic acc;
    acc      = 1'b0;
    in_valid = 1'b1;
    a        = av;
    b        = bv;
    cin      = ci;
    mode     = md;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (ir_m) begin
        acc = 1'b1;
        exp_q.push_back(use_ref ? ref_model(width_of(lane), av, bv, ci, md) : given);
        cyc_q.push_back(cyc);
      end
      @(posedge clk);
      #1;
      if (acc) break;
    end
    in_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: beat never accepted on lane %0d", lane);
    end
  endtask

  task automatic send_rand();
    logic [63:0] av;
    logic [63:0] bv;
    logic [63:0] msb;
    msb = 64'd1 << (width_of(lane) - 1);
    av  = {$urandom, $urandom};
    bv  = {$urandom, $urandom};
    case ($urandom_range(0, 7))
      0: av = '1;
      1: bv = '1;
      2: av = msb;
      3: bv = msb - 64'd1;
      default: ;
    endcase
    send(av, bv, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'b1, '0);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    ready_rand = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results outstanding, required 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: handshake rule, hold-while-stalled, ordered data, latency.
  logic        prev_stall;
  logic [66:0] prev_out;
  logic [66:0] exp_v;
  int          stamp;
  initial begin
    prev_stall = 1'b0;
    prev_out   = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        checks++;
        if (ir_m !== !(ov_m && !out_ready)) begin
          errors++;
          $display("FAIL in_ready: got %b with out_valid=%b out_ready=%b", ir_m, ov_m, out_ready);
        end
        if (prev_stall) begin
          check("stall_hold", {ov_m, out_m}, {1'b1, prev_out});
        end
        if (ov_m && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got %h with nothing outstanding", out_m);
          end else begin
            exp_v = exp_q.pop_front();
            stamp = cyc_q.pop_front();
            check("result", out_m, exp_v);
            if (lat_check) check("latency", 67'(cyc - stamp), 67'(lat_of(lane)));
          end
        end
        prev_stall = ov_m && !out_ready;
        prev_out   = out_m;
      end
    end
  end

  // Main sequence
  int low_cnt;
  int quiet_bad;
  initial begin
    errors     = 0;
    checks     = 0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    a          = '0;
    b          = '0;
    cin        = 1'b0;
    mode       = 2'b00;
    lane       = 2'd2;
    ready_rand = 1'b0;
    hold_low   = 1'b0;
    lat_check  = 1'b1;

    // Reset state on every lane
    #2;
    for (int l = 0; l < 4; l++) begin
      lane = 2'(l);
      #1;
      check("rst_out_valid", 67'(ov_m), 67'd0);
      check("rst_outputs", out_m, 67'd0);
      check("rst_in_ready", 67'(ir_m), 67'd1);
    end
    lane = 2'd2;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed vectors, WIDTH=32; the first beat goes in on the first edge out of reset
    send(64'hFFFFFFFF, 64'hFFFFFFFF, 1'b0, 2'b00, 1'b0, pk(1'b0, 1'b0, 1'b1, 64'hFFFFFFFE));
    send(64'h00000000, 64'h00000001, 1'b0, 2'b01, 1'b0, pk(1'b0, 1'b0, 1'b0, 64'hFFFFFFFF));
    send(64'h80000000, 64'h00000001, 1'b0, 2'b01, 1'b0, pk(1'b0, 1'b1, 1'b1, 64'h7FFFFFFF));
    send(64'h00000000, 64'hFFFFFFFF, 1'b1, 2'b10, 1'b0, pk(1'b1, 1'b0, 1'b1, 64'h00000000));
    send(64'h00000000, 64'hFFFFFFFF, 1'b0, 2'b10, 1'b0, pk(1'b0, 1'b0, 1'b0, 64'hFFFFFFFF));
    send(64'h00000005, 64'h00000003, 1'b1, 2'b11, 1'b0, pk(1'b0, 1'b0, 1'b1, 64'h00000002));
    drain();

    // WIDTH=8 signed overflow
    lane = 2'd1;
    send(64'h7F, 64'h01, 1'b0, 2'b00, 1'b0, pk(1'b0, 1'b1, 1'b0, 64'h80));
    drain();

    // Ten back-to-back beats with the consumer stalled for four cycles
    lane      = 2'd2;
    lat_check = 1'b0;
    low_cnt   = 0;
    fork
      begin
        for (int i = 0; i < 10; i++) send_rand();
      end
      begin
        repeat (8) @(posedge clk);
        hold_low = 1'b1;
        repeat (4) begin
          @(negedge clk);
          if (!ir_m) low_cnt++;
        end
        @(posedge clk);
        hold_low = 1'b0;
      end
    join
    check("stall_in_ready_low_cycles", 67'(low_cnt), 67'd4);
    drain();

    // Reset while three beats are in flight and the head is stalled
    hold_low = 1'b1;
    for (int i = 0; i < 3; i++) send_rand();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ov_m) break;
    end
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 67'(ov_m), 67'd0);
    check("midrst_outputs", out_m, 67'd0);
    check("midrst_in_ready", 67'(ir_m), 67'd1);
    exp_q.delete();
    cyc_q.delete();
    hold_low = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    lat_check = 1'b1;
    quiet_bad = 0;
    for (int i = 0; i < 2 * lat_of(lane); i++) begin
      @(negedge clk);
      if (ov_m) quiet_bad++;
    end
    @(posedge clk);
    #1;
    check("post_reset_quiet", 67'(quiet_bad), 67'd0);
    send(64'h12345678, 64'h11111111, 1'b0, 2'b00, 1'b0, pk(1'b0, 1'b0, 1'b0, 64'h23456789));
    drain();

    // Randomised traffic on every width with random bubbles and back-pressure
    lat_check = 1'b0;
    for (int l = 0; l < 4; l++) begin
      lane       = 2'(l);
      ready_rand = 1'b1;
      for (int n = 0; n < 2500; n++) begin
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        send_rand();
      end
      drain();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
